// File: rtl/reg_bank_pkg.sv
// Shared sizing constants and helpers for the arbitrated register bank.
package reg_bank_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int NREQ_DEF  = 4;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);
    localparam int IW_DEF    = $clog2(NREQ_DEF);

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after i_ptr,
// returned both one-hot and encoded.
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IW-1:0]     w_off;
    logic [IW:0]       w_sum;
    logic [IW:0]       w_wrapped;

    // Rotate so the pointer position lands at bit 0, then find the lowest set bit.
    assign w_dbl = {i_valid, i_valid} >> i_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    assign w_sum     = {1'b0, i_ptr} + {1'b0, w_off};
    assign w_wrapped = (w_sum >= (IW+1)'(NREQ)) ? (w_sum - (IW+1)'(NREQ)) : w_sum;
    assign o_idx     = w_wrapped[IW-1:0];
    assign o_any     = |i_valid;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign o_grant[gi] = o_any && (o_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NREQ round-robin write requesters, with one
// registered read port. Storage is flops so reset clears every entry.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH),
    parameter int NREQ  = NREQ_DEF,
    parameter int IW    = idx_width(NREQ)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH-1:0]      written,
    output logic [IW-1:0]         last_grant,
    output logic                  grant_valid
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_written;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_last_grant;
    logic             r_grant_valid;
    logic [WIDTH-1:0] r_rd_data;

    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [IW-1:0]    w_ptr_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready  = Rst ? '0 : w_grant;
    assign w_waddr    = req_addr[w_idx*AW +: AW];
    assign w_wdata    = req_data[w_idx*WIDTH +: WIDTH];
    assign w_ptr_next = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    // Read samples pre-edge contents, so a same-cycle write shows up one read later.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_written     <= '0;
            r_ptr         <= '0;
            r_last_grant  <= '0;
            r_grant_valid <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_rd_data     <= r_mem[rd_addr];
            r_grant_valid <= w_any;
            if (w_any) begin
                r_mem[w_waddr]     <= w_wdata;
                r_written[w_waddr] <= 1'b1;
                r_ptr              <= w_ptr_next;
                r_last_grant       <= w_idx;
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign written     = r_written;
    assign last_grant  = r_last_grant;
    assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the arbitrated register bank.
module tb_reg_bank_arbiter;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            Clk = 1'b0;
    logic            Rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rd_addr;
    logic [W-1:0]    rd_data;
    logic [D-1:0]    written;
    logic [IW-1:0]   last_grant;
    logic            grant_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_mem [D];
    logic [D-1:0] m_written;
    int           m_ptr;
    logic [W-1:0] m_rd;
    int           m_last;
    logic         m_gv;
    int           m_wait [N];

    always #5 Clk = ~Clk;

    reg_bank_arbiter #(
        .WIDTH (W),
        .DEPTH (D),
        .AW    (AW),
        .NREQ  (N)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .written     (written),
        .last_grant  (last_grant),
        .grant_valid (grant_valid)
    );

    // Build the search order starting at the pointer and take the first valid one.
    function automatic int model_pick();
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) begin
            if (req_valid[order[j]]) return order[j];
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        if (Rst) return '0;
        g = model_pick();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[i]           = v;
        req_addr[i*AW +: AW]   = a;
        req_data[i*W +: W]     = d;
    endtask

    // Advance one clock edge and update the model with the pre-edge inputs.
    task automatic tick();
        int g;
        int a;
        g = Rst ? -1 : model_pick();
        @(posedge Clk);
        if (Rst) begin
            for (int k = 0; k < D; k++) m_mem[k] = '0;
            m_written = '0;
            m_ptr = 0;
            m_rd = '0;
            m_last = 0;
            m_gv = 1'b0;
            for (int k = 0; k < N; k++) m_wait[k] = 0;
        end else begin
            m_rd = m_mem[rd_addr];
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && k != g) m_wait[k]++;
            end
            if (g >= 0) begin
                a = int'(req_addr[g*AW +: AW]);
                m_mem[a] = req_data[g*W +: W];
                m_written[a] = 1'b1;
                m_ptr = (g + 1) % N;
                m_last = g;
                m_gv = 1'b1;
                $display("grant req=%0d addr=%0d data=%h t=%0t", g, a, req_data[g*W +: W], $time);
            end else begin
                m_gv = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), 8'hF0);
        rd_addr = '0;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data);
        end
        checks++;
        if (written !== 8'h00) begin
            failures++; $display("FAIL reset_written got=%b exp=00000000", written);
        end
        checks++;
        if (grant_valid !== 1'b0 || last_grant !== 2'd0) begin
            failures++; $display("FAIL reset_grant got gv=%b lg=%0d exp gv=0 lg=0", grant_valid, last_grant);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
        end
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), 8'hA0 + 8'(i));
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== (N'(1) << seq[c]) || req_ready !== exp_ready()) begin
                failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready, N'(1) << seq[c]);
            end
            tick();
            checks++;
            if (grant_valid !== 1'b1 || last_grant !== IW'(seq[c])) begin
                failures++; $display("FAIL rr_last cyc=%0d got gv=%b lg=%0d exp gv=1 lg=%0d", c, grant_valid, last_grant, seq[c]);
            end
        end
        req_valid = '0;
        rd_addr = 3'd2;
        tick();
        checks++;
        if (rd_data !== 8'hA2) begin
            failures++; $display("FAIL rr_read got=%h exp=a2", rd_data);
        end
        checks++;
        if (written !== 8'b0000_1111 || grant_valid !== 1'b0) begin
            failures++; $display("FAIL rr_written got=%b gv=%b exp=00001111 gv=0", written, grant_valid);
        end
    endtask

    task automatic test_ptr_wrap();
        set_req(2, 1'b1, 3'd4, 8'h5A);
        tick();
        req_valid = '0;
        set_req(1, 1'b1, 3'd1, 8'h61);
        set_req(3, 1'b1, 3'd3, 8'h63);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL wrap_first got=%b exp=1000", req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL wrap_second got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = 4'b1111;
        #1;
        checks++;
        if (last_grant !== 2'd1 || req_ready !== 4'b0100) begin
            failures++; $display("FAIL wrap_ptr got lg=%0d ready=%b exp lg=1 ready=0100", last_grant, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_read_during_write();
        set_req(0, 1'b1, 3'd5, 8'h11);
        tick();
        req_valid = '0;
        set_req(2, 1'b1, 3'd5, 8'h22);
        rd_addr = 3'd5;
        #1;
        checks++;
        if (req_ready !== exp_ready() || req_ready[2] !== 1'b1) begin
            failures++; $display("FAIL rdw_ready got=%b exp=%b", req_ready, exp_ready());
        end
        tick();
        req_valid = '0;
        checks++;
        if (rd_data !== 8'h11) begin
            failures++; $display("FAIL rdw_old got=%h exp=11", rd_data);
        end
        tick();
        checks++;
        if (rd_data !== 8'h22) begin
            failures++; $display("FAIL rdw_new got=%h exp=22", rd_data);
        end
    endtask

    task automatic test_collision();
        set_req(3, 1'b1, 3'd0, 8'h77);
        tick();
        req_valid = '0;
        set_req(0, 1'b1, 3'd7, 8'h33);
        set_req(1, 1'b1, 3'd7, 8'h44);
        tick();
        req_valid[0] = 1'b0;
        checks++;
        if (grant_valid !== 1'b1 || last_grant !== 2'd0) begin
            failures++; $display("FAIL coll_first got gv=%b lg=%0d exp gv=1 lg=0", grant_valid, last_grant);
        end
        tick();
        req_valid = '0;
        rd_addr = 3'd7;
        checks++;
        if (grant_valid !== 1'b1 || last_grant !== 2'd1) begin
            failures++; $display("FAIL coll_second got gv=%b lg=%0d exp gv=1 lg=1", grant_valid, last_grant);
        end
        tick();
        checks++;
        if (rd_data !== 8'h44 || grant_valid !== 1'b0) begin
            failures++; $display("FAIL coll_final got=%h gv=%b exp=44 gv=0", rd_data, grant_valid);
        end
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 3'd6, 8'h55);
        Rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL rstmid_ready got=%b exp=0000", req_ready);
        end
        tick();
        Rst = 1'b0;
        req_valid = '0;
        rd_addr = 3'd6;
        tick();
        checks++;
        if (rd_data !== 8'h00 || written !== 8'h00) begin
            failures++; $display("FAIL rstmid_mem got=%h written=%b exp=00 written=00000000", rd_data, written);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL rstmid_ptr got=%b exp=0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'b1, AW'($urandom_range(0, D - 1)), W'($urandom));
            end
            Rst = ($urandom_range(0, 39) == 0);
            rd_addr = AW'($urandom_range(0, D - 1));
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready());
            end
            tick();
            if (m_gv) begin
                checks++;
                if (m_wait[m_last] >= N) begin
                    failures++; $display("FAIL rand_fair cyc=%0d req=%0d waited=%0d max=%0d", c, m_last, m_wait[m_last], N - 1);
                end
                m_wait[m_last] = 0;
                req_valid[m_last] = 1'b0;
            end
            checks++;
            if (rd_data !== m_rd || written !== m_written || grant_valid !== m_gv || last_grant !== IW'(m_last)) begin
                failures++;
                $display("FAIL rand_state cyc=%0d got rd=%h wr=%b gv=%b lg=%0d exp rd=%h wr=%b gv=%b lg=%0d",
                         c, rd_data, written, grant_valid, last_grant, m_rd, m_written, m_gv, m_last);
            end
        end
        Rst = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        rd_addr = '0;
        m_ptr = 0;
        m_last = 0;
        m_gv = 1'b0;
        m_rd = '0;
        m_written = '0;
        for (int k = 0; k < D; k++) m_mem[k] = '0;
        for (int k = 0; k < N; k++) m_wait[k] = 0;
        #2;
        test_reset();
        test_round_robin();
        test_ptr_wrap();
        test_read_during_write();
        test_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shares a bank of DEPTH WIDTH-bit registers, the same clocked, synchronously reset storage element used throughout the datapath library, between NREQ write requesters. Grants at most one write per cycle using round-robin priority, and serves a single registered read port. Sits between the scheduled datapath units (ALU/MUL/DIV outputs) and the shared result storage, so several functional units can target one register bank without external muxing.

## Interface
- WIDTH, 8, data width of each register
- DEPTH, 8, number of registers in the bank (power of two, ≥2)
- AW, 3, address width, equals log2(DEPTH)
- NREQ, 4, number of write requesters (≥2)

- Clk  in  1  single clock; all state updates on posedge Clk
- Rst  in  1  synchronous, active-high reset, sampled on posedge Clk
- req_valid  in  NREQ  bit i: requester i has a write pending
- req_addr  in  NREQ*AW  requester i target address in bits [i*AW +: AW]
- req_data  in  NREQ*WIDTH  requester i write data in bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot (or zero) grant; a write by i completes when req_valid[i] && req_ready[i] at a posedge
- rd_addr  in  AW  read address, sampled every posedge
- rd_data  out  WIDTH  registered read data
- written  out  DEPTH  bit k set once register k has been written since reset
- last_grant  out  log2(NREQ)  index of the most recently granted requester (registered)
- grant_valid  out  1  registered; 1 in the cycle after a write was accepted

## Operation
- Round-robin pointer ptr (log2(NREQ) bits) names the highest-priority requester; search order is ptr, ptr+1, … wrapping modulo NREQ.
- req_ready is combinational from req_valid and ptr: exactly one bit is set, for the first valid requester in search order; all zeros if no requester is valid or Rst=1.
- On a grant to requester g: mem[req_addr[g]] <= req_data[g]; written[addr] <= 1; ptr <= g+1 (mod NREQ); last_grant <= g; grant_valid <= 1.
- No grant: mem, written, ptr, last_grant hold; grant_valid <= 0.
- Requesters that are not granted keep their request pending; the block does not queue or drop requests. A requester must hold addr/data stable while valid and not ready.
- Read: rd_data <= mem[rd_addr] each posedge using the pre-edge contents. A read and a write to the same address in the same cycle return the old value. The new value appears on the read one cycle later.
- Two requesters targeting the same address are serialized by the arbitration order; the last one granted wins.
- Reset: mem all 0, written=0, ptr=0, rd_data=0, last_grant=0, grant_valid=0; req_ready=0 while Rst=1. A request pending at reset is not accepted and is granted normally after Rst deasserts if still valid. Reset takes precedence over a simultaneous grant.

## Timing
- Grant decision: 0 cycles (same-cycle req_ready); write commits at that posedge.
- Write-to-read visibility: read issued the cycle after the accepting edge sees new data one edge later (2 edges from grant cycle start).
- Read latency: 1 cycle, rd_addr → rd_data.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- No combinational path from rd_addr to rd_data; req_ready depends only on req_valid, ptr, Rst.

## Structure
- Shared package reg_bank_pkg: WIDTH/DEPTH/NREQ defaults, AW derivation, requester-index width constant.
- One sub-module: rr_arbiter (NREQ-bit valid in, ptr in, one-hot grant + encoded index out, purely combinational). The pointer register stays in reg_bank_arbiter.
- Storage is DEPTH registers with synchronous reset. No RAM inference, because reset must clear contents.

## Test plan
- Reset: drive Rst=1 with req_valid=4'b1111 → req_ready=0, rd_data=0, written=0; after release, first grant goes to requester 0 (req_ready=4'b0001).
- Round-robin: all four valid continuously, each writing addr=i, data=8'hA0+i → grants 0,1,2,3,0 on successive cycles; reading addr 2 then returns 8'hA2; written=8'b0000_1111.
- Pointer wrap and skip: ptr=3, only requesters 1 and 3 valid → grant 3, next cycle grant 1, ptr=2 afterwards.
- Read-during-write: mem[5]=8'h11, requester 2 writes 8'h22 to addr 5 while rd_addr=5 → rd_data=8'h11 next cycle, 8'h22 the cycle after.
- Same-address collision: requesters 0 and 1 both write addr 7 (8'h33, 8'h44) from ptr=0 → final mem[7]=8'h44, last_grant=1, grant_valid high for 2 cycles.
- Reset mid-operation: Rst asserted during a grant cycle → write not committed, mem[addr] stays 0, ptr=0 after reset.
